key_conditioner: RTL and testbench

- Input stage directly upstream of the game logic FSM.
- Takes three raw, bouncy, asynchronous push-button levels (left, right, down) and conditions them:
  - synchronises them to vclk;
  - debounces them;
  - converts presses into single-cycle move pulses LEFT/RIGHT/DOWN, aligned to the video frame strobe.
- Holding a button gives auto-repeat after an initial delay, at most one pulse per button per frame.

---
 rtl/key_conditioner.sv | 141 ++++++++++++++
 tb/tb_key_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop sync, per-button debounce, and frame-aligned
// single-cycle move pulses with auto-repeat while a button is held.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18,
  parameter int REPEAT_DELAY    = 12,
  parameter int REPEAT_PERIOD   = 4,
  parameter int DOWN_PERIOD     = 2,
  parameter int FR_W            = 6
) (
  input  logic       vclk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       frame,
  output logic       LEFT,
  output logic       RIGHT,
  output logic       DOWN,
  output logic [2:0] held
);

  typedef enum logic [1:0] {IDLE, ARMED, DELAY, REPEAT} state_t;

  localparam int NB = 3;

  logic [NB-1:0]   raw, sync1, sync2, stable;
  logic [DB_W-1:0] db_cnt [NB];
  logic [FR_W-1:0] fr_cnt [NB];
  state_t          state  [NB];
  logic [NB-1:0]   emit, pulse;

  // Bit order everywhere is {down, right, left}.
  assign raw  = {btn_down, btn_right, btn_left};
  assign held = stable;

  function automatic logic [FR_W-1:0] period_m1(input int unsigned idx);
    return (idx == 2) ? FR_W'(DOWN_PERIOD - 1) : FR_W'(REPEAT_PERIOD - 1);
  endfunction

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Emit decisions for the current frame cycle; a release in ARMED still emits.
  always_comb begin
    emit = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      case (state[i])
        ARMED:   emit[i] = frame;
        DELAY:   emit[i] = frame && stable[i] && (fr_cnt[i] == FR_W'(REPEAT_DELAY - 1));
        REPEAT:  emit[i] = frame && stable[i] && (fr_cnt[i] == period_m1(i));
        default: emit[i] = 1'b0;
      endcase
    end
    pulse = emit;
    if (emit[0] && emit[1]) pulse[1:0] = 2'b00;
  end

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NB; i++) begin
        state[i]  <= IDLE;
        fr_cnt[i] <= '0;
      end
      LEFT  <= 1'b0;
      RIGHT <= 1'b0;
      DOWN  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        case (state[i])
          IDLE: begin
            fr_cnt[i] <= '0;
            if (stable[i]) state[i] <= ARMED;
          end
          ARMED: begin
            if (frame) begin
              fr_cnt[i] <= '0;
              state[i]  <= stable[i] ? DELAY : IDLE;
            end
          end
          DELAY: begin
            if (!stable[i]) begin
              state[i]  <= IDLE;
              fr_cnt[i] <= '0;
            end else if (frame) begin
              if (emit[i]) begin
                fr_cnt[i] <= '0;
                state[i]  <= REPEAT;
              end else begin
                fr_cnt[i] <= fr_cnt[i] + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (!stable[i]) begin
              state[i]  <= IDLE;
              fr_cnt[i] <= '0;
            end else if (frame) begin
              fr_cnt[i] <= emit[i] ? '0 : fr_cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i]  <= IDLE;
            fr_cnt[i] <= '0;
          end
        endcase
      end
      LEFT  <= pulse[0];
      RIGHT <= pulse[1];
      DOWN  <= pulse[2];
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: scenarios push expected pulses/held
// levels keyed by cycle; a negedge monitor pops and compares.
module tb_key_conditioner;

  logic       vclk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0;
  logic       frame = 1'b0;
  logic       LEFT, RIGHT, DOWN;
  logic [2:0] held;

  always #5 vclk = ~vclk;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .DB_W(3),
    .REPEAT_DELAY(3),
    .REPEAT_PERIOD(2),
    .DOWN_PERIOD(1),
    .FR_W(6)
  ) dut (
    .vclk(vclk),
    .rst(rst),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_down(btn_down),
    .frame(frame),
    .LEFT(LEFT),
    .RIGHT(RIGHT),
    .DOWN(DOWN),
    .held(held)
  );

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } ev_t;

  ev_t pulse_q[$];
  ev_t held_q[$];

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  bit running = 1'b0;

  int rst_a, rst_b, l_a, l_b, r_a, r_b, r2_a, r2_b, d_a, d_b;
  bit bounce;

  task automatic new_scn();
    base = cyc + 1;
    rst_a = 0; rst_b = 0;
    l_a = 0;  l_b = 0;
    r_a = 0;  r_b = 0;
    r2_a = 0; r2_b = 0;
    d_a = 0;  d_b = 0;
    bounce = 1'b0;
  endtask

  task automatic exp_pulse(input int rel, input logic [2:0] v);
    pulse_q.push_back(ev_t'{base + rel, v});
  endtask

  task automatic exp_held(input int rel, input logic [2:0] v);
    held_q.push_back(ev_t'{base + rel, v});
  endtask

  function automatic bit win(input int rel, input int a, input int b);
    return (rel >= a) && (rel < b);
  endfunction

  // Inputs change 1 time unit after the rising edge; rel is the cycle index.
  task automatic run(input int n);
    for (int rel = 0; rel < n; rel++) begin
      @(posedge vclk);
      #1;
      cyc       = base + rel;
      rst       = (rel < 5) || win(rel, rst_a, rst_b);
      btn_left  = win(rel, l_a, l_b) && (!bounce || ((rel - l_a) % 6 < 3));
      btn_right = win(rel, r_a, r_b) || win(rel, r2_a, r2_b);
      btn_down  = win(rel, d_a, d_b);
      frame     = (rel % 20 == 0) && (rel > 0);
    end
  endtask

  always @(negedge vclk) begin
    logic [2:0] out;
    ev_t        e;
    if (running) begin
      out = {DOWN, RIGHT, LEFT};
      while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
        e = pulse_q.pop_front();
        tests++;
        failures++;
        $display("FAIL pulse_missing cycle=%0d got=%b need=%b", e.cyc, 3'b000, e.val);
      end
      if (out != 3'b000) begin
        tests++;
        if (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) begin
          e = pulse_q.pop_front();
          if (out != e.val) begin
            failures++;
            $display("FAIL pulse_value cycle=%0d got=%b need=%b", cyc, out, e.val);
          end
        end else begin
          failures++;
          $display("FAIL pulse_unexpected cycle=%0d got=%b need=%b", cyc, out, 3'b000);
        end
      end
      while (held_q.size() > 0 && held_q[0].cyc <= cyc) begin
        e = held_q.pop_front();
        tests++;
        if (e.cyc != cyc || held != e.val) begin
          failures++;
          $display("FAIL held cycle=%0d got=%b need=%b", e.cyc, held, e.val);
        end
      end
    end
  end

  initial begin
    running = 1'b1;

    // Left held through reset release, then auto-repeat until release.
    new_scn();
    l_a = 1; l_b = 190;
    exp_held(2, 3'b000); exp_held(10, 3'b000); exp_held(11, 3'b001);
    exp_held(100, 3'b001); exp_held(195, 3'b001); exp_held(196, 3'b000);
    exp_pulse(21, 3'b001); exp_pulse(81, 3'b001);
    exp_pulse(121, 3'b001); exp_pulse(161, 3'b001);
    run(220);

    // 3-cycle bursts on left must never be accepted.
    new_scn();
    l_a = 10; l_b = 40; bounce = 1'b1;
    exp_held(20, 3'b000); exp_held(38, 3'b000); exp_held(50, 3'b000);
    run(100);

    // Down: delay then one pulse per frame; release before frame 120.
    new_scn();
    d_a = 1; d_b = 100;
    exp_held(11, 3'b100); exp_held(105, 3'b100); exp_held(106, 3'b000);
    exp_pulse(21, 3'b100); exp_pulse(81, 3'b100); exp_pulse(101, 3'b100);
    run(220);

    // Left+right conflict suppressed every time; down unaffected.
    new_scn();
    l_a = 1; l_b = 190; r_a = 1; r_b = 190; d_a = 1; d_b = 190;
    exp_held(11, 3'b111); exp_held(150, 3'b111); exp_held(196, 3'b000);
    exp_pulse(21, 3'b100); exp_pulse(81, 3'b100); exp_pulse(101, 3'b100);
    exp_pulse(121, 3'b100); exp_pulse(141, 3'b100); exp_pulse(161, 3'b100);
    exp_pulse(181, 3'b100);
    run(220);

    // Right tap released while armed, then reset mid-press forces re-debounce.
    new_scn();
    l_a = 1; l_b = 44;
    r_a = 22; r_b = 31; r2_a = 43; r2_b = 110;
    rst_a = 45; rst_b = 60;
    exp_held(11, 3'b001); exp_held(27, 3'b001); exp_held(28, 3'b011);
    exp_held(36, 3'b011); exp_held(37, 3'b001); exp_held(44, 3'b001);
    exp_held(46, 3'b000); exp_held(65, 3'b000); exp_held(66, 3'b010);
    exp_held(115, 3'b010); exp_held(116, 3'b000);
    exp_pulse(21, 3'b001); exp_pulse(41, 3'b010); exp_pulse(81, 3'b010);
    run(140);

    new_scn();
    run(10);
    running = 1'b0;

    while (pulse_q.size() > 0) begin
      ev_t e;
      e = pulse_q.pop_front();
      tests++;
      failures++;
      $display("FAIL pulse_never_seen cycle=%0d got=%b need=%b", e.cyc, 3'b000, e.val);
    end
    while (held_q.size() > 0) begin
      ev_t e;
      e = held_q.pop_front();
      tests++;
      failures++;
      $display("FAIL held_never_checked cycle=%0d got=%b need=%b", e.cyc, held, e.val);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
